decode_stage: RTL and testbench

//  Parametrised decode stage for the ARM-subset core. Sits between fetch and execute.

---
 rtl/decode_stage.sv | 188 ++++++++++++++++++
 tb/tb_decode_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: instruction FIFO feeding a registered decode bundle with condition evaluation.
// Optional branch decoding is enabled by defining DECODE_BRANCH_EN.
module decode_stage #(
    parameter int DEPTH     = 2,
    parameter int REG_W     = 4,
    parameter int OPERAND_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          inst,
    input  logic [3:0]           flags,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           alu_op,
    output logic [5:0]           mf_op,
    output logic [REG_W-1:0]     reg_n,
    output logic [REG_W-1:0]     reg_d,
    output logic [OPERAND_W-1:0] operand,
    output logic                 s_cpsr,
    output logic                 dp_dt,
    output logic                 r_i,
    output logic                 cond_pass,
`ifdef DECODE_BRANCH_EN
    output logic                 br,
    output logic                 br_link,
    output logic [23:0]          br_off,
`endif
    output logic                 undef
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]           alu_op;
        logic [5:0]           mf_op;
        logic [REG_W-1:0]     reg_n;
        logic [REG_W-1:0]     reg_d;
        logic [OPERAND_W-1:0] operand;
        logic                 s_cpsr;
        logic                 dp_dt;
        logic                 r_i;
        logic                 cond_pass;
        logic                 undef;
`ifdef DECODE_BRANCH_EN
        logic                 br;
        logic                 br_link;
        logic [23:0]          br_off;
`endif
    } bundle_t;

    logic [31:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_out_valid;
    bundle_t     r_bundle;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_load;
    logic [31:0] w_head;
    logic [3:0]  w_cond;
    logic [1:0]  w_fmt;
    logic        w_fmt_undef;
    bundle_t     w_dec;

    // Both sides: a transfer happens on a rising edge where valid && ready are both high;
    // a valid producer holds its data until that edge. A flush edge transfers nothing.
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign in_ready = !rst && !w_full;
    assign w_push   = in_valid && in_ready && !flush;
    assign w_load   = !w_empty && (!r_out_valid || out_ready) && !flush;
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_cond   = w_head[31:28];
    assign w_fmt    = w_head[27:26];

    // flags bit3..0 = N,Z,C,V
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'h0:    cond_eval = z;
            4'h1:    cond_eval = !z;
            4'h2:    cond_eval = cy;
            4'h3:    cond_eval = !cy;
            4'h4:    cond_eval = n;
            4'h5:    cond_eval = !n;
            4'h6:    cond_eval = v;
            4'h7:    cond_eval = !v;
            4'h8:    cond_eval = cy && !z;
            4'h9:    cond_eval = !cy || z;
            4'hA:    cond_eval = (n == v);
            4'hB:    cond_eval = (n != v);
            4'hC:    cond_eval = !z && (n == v);
            4'hD:    cond_eval = z || (n != v);
            4'hE:    cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

`ifdef DECODE_BRANCH_EN
    assign w_fmt_undef = (w_fmt == 2'b11);
`else
    assign w_fmt_undef = w_fmt[1];
`endif

    always_comb begin
        w_dec           = '0;
        w_dec.reg_n     = w_head[16 +: REG_W];
        w_dec.reg_d     = w_head[12 +: REG_W];
        w_dec.cond_pass = cond_eval(w_cond, flags);
        w_dec.undef     = (w_cond == 4'hF) || w_fmt_undef;
        if (!w_dec.undef) begin
            w_dec.operand = w_head[OPERAND_W-1:0];
            case (w_fmt)
                2'b00: begin
                    w_dec.dp_dt  = 1'b1;
                    w_dec.alu_op = w_head[24:21];
                    w_dec.s_cpsr = w_head[20];
                    w_dec.r_i    = !w_head[25];
                end
                2'b01: w_dec.mf_op = w_head[25:20];
                default: begin
`ifdef DECODE_BRANCH_EN
                    w_dec.br      = 1'b1;
                    w_dec.br_link = w_head[24];
                    w_dec.br_off  = w_head[23:0];
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_bundle    <= '0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_load) begin
                r_rd_ptr    <= r_rd_ptr + (AW+1)'(1);
                r_bundle    <= w_dec;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign alu_op    = r_bundle.alu_op;
    assign mf_op     = r_bundle.mf_op;
    assign reg_n     = r_bundle.reg_n;
    assign reg_d     = r_bundle.reg_d;
    assign operand   = r_bundle.operand;
    assign s_cpsr    = r_bundle.s_cpsr;
    assign dp_dt     = r_bundle.dp_dt;
    assign r_i       = r_bundle.r_i;
    assign cond_pass = r_bundle.cond_pass;
    assign undef     = r_bundle.undef;
`ifdef DECODE_BRANCH_EN
    assign br        = r_bundle.br;
    assign br_link   = r_bundle.br_link;
    assign br_off    = r_bundle.br_off;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vector table, scoreboard queue, flush/reset/backpressure sequences.
// Branch expectations follow DECODE_BRANCH_EN when it is defined.
module tb_decode_stage;

`ifdef DECODE_BRANCH_EN
    localparam int BW = 61;
`else
    localparam int BW = 35;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] inst;
    logic [3:0]  flags;
    logic [3:0]  alu_op;
    logic [5:0]  mf_op;
    logic [3:0]  reg_n, reg_d;
    logic [11:0] operand;
    logic        s_cpsr, dp_dt, r_i, cond_pass, undef;
    logic [BW-1:0] got;
`ifdef DECODE_BRANCH_EN
    logic        br, br_link;
    logic [23:0] br_off;
`endif

    decode_stage #(.DEPTH(2), .REG_W(4), .OPERAND_W(12)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .flags(flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .mf_op(mf_op), .reg_n(reg_n), .reg_d(reg_d), .operand(operand),
        .s_cpsr(s_cpsr), .dp_dt(dp_dt), .r_i(r_i), .cond_pass(cond_pass),
`ifdef DECODE_BRANCH_EN
        .br(br), .br_link(br_link), .br_off(br_off),
`endif
        .undef(undef)
    );

`ifdef DECODE_BRANCH_EN
    assign got = {alu_op, mf_op, reg_n, reg_d, operand, s_cpsr, dp_dt, r_i, cond_pass, undef,
                  br, br_link, br_off};
`else
    assign got = {alu_op, mf_op, reg_n, reg_d, operand, s_cpsr, dp_dt, r_i, cond_pass, undef};
`endif

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [BW-1:0] exp_q[$];
    int hs_cyc[$];
    logic bp_en = 1'b0;

    typedef struct {
        logic [31:0]   ins;
        logic [3:0]    fl;
        logic [BW-1:0] exp;
    } vec_t;
    vec_t tbl[15];

    function automatic logic [BW-1:0] mk(input logic [3:0] a, input logic [5:0] m,
                                         input logic [3:0] rn, input logic [3:0] rd,
                                         input logic [11:0] op, input logic s, input logic dp,
                                         input logic ri, input logic cp, input logic ud);
        logic [34:0] b;
        b = {a, m, rn, rd, op, s, dp, ri, cp, ud};
`ifdef DECODE_BRANCH_EN
        mk = {b, 26'h0};
`else
        mk = b;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: compare on every accepted output handshake.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            total++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_bundle actual=%h required=none", got);
            end else begin
                logic [BW-1:0] e;
                e = exp_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL bundle actual=%h required=%h", got, e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic push(input logic [31:0] ins, input logic [BW-1:0] e);
        int n;
        n = 0;
        in_valid = 1'b1;
        inst     = ins;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL push_timeout actual=in_ready_low required=accept");
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [BW-1:0] e_br;
        int pick[8];
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] e_br;
        int al_set[8];
`ifdef DECODE_BRANCH_EN
        e_br = {mk(0, 0, 0, 0, 12'h010, 0, 0, 0, 1, 0)} | {{35{1'b0}}, 1'b1, 1'b0, 24'h000010};
`else
        e_br = mk(0, 0, 0, 0, 12'h000, 0, 0, 0, 1, 1);
`endif
        tbl[0]  = '{32'he0810002, 4'h0, mk(4'h4, 6'h00, 1, 0, 12'h002, 0, 1, 1, 1, 0)};
        tbl[1]  = '{32'he0443005, 4'h0, mk(4'h2, 6'h00, 4, 3, 12'h005, 0, 1, 1, 1, 0)};
        tbl[2]  = '{32'he1a07128, 4'h0, mk(4'hD, 6'h00, 0, 7, 12'h128, 0, 1, 1, 1, 0)};
        tbl[3]  = '{32'he5912004, 4'h0, mk(4'h0, 6'h19, 1, 2, 12'h004, 0, 0, 0, 1, 0)};
        tbl[4]  = '{32'he2911001, 4'h0, mk(4'h4, 6'h00, 1, 1, 12'h001, 1, 1, 0, 1, 0)};
        tbl[5]  = '{32'h00810002, 4'h4, mk(4'h4, 6'h00, 1, 0, 12'h002, 0, 1, 1, 1, 0)};
        tbl[6]  = '{32'h00810002, 4'h0, mk(4'h4, 6'h00, 1, 0, 12'h002, 0, 1, 1, 0, 0)};
        tbl[7]  = '{32'hc0810002, 4'h0, mk(4'h4, 6'h00, 1, 0, 12'h002, 0, 1, 1, 1, 0)};
        tbl[8]  = '{32'hc0810002, 4'h8, mk(4'h4, 6'h00, 1, 0, 12'h002, 0, 1, 1, 0, 0)};
        tbl[9]  = '{32'h80810002, 4'h2, mk(4'h4, 6'h00, 1, 0, 12'h002, 0, 1, 1, 1, 0)};
        tbl[10] = '{32'hb0810002, 4'h8, mk(4'h4, 6'h00, 1, 0, 12'h002, 0, 1, 1, 1, 0)};
        tbl[11] = '{32'hfc000000, 4'h0, mk(4'h0, 6'h00, 0, 0, 12'h000, 0, 0, 0, 0, 1)};
        tbl[12] = '{32'hec000000, 4'h0, mk(4'h0, 6'h00, 0, 0, 12'h000, 0, 0, 0, 1, 1)};
        tbl[13] = '{32'hea000010, 4'h0, e_br};
        tbl[14] = '{32'h15912004, 4'h4, mk(4'h0, 6'h19, 1, 2, 12'h004, 0, 0, 0, 0, 0)};
        al_set = '{0, 1, 2, 3, 4, 11, 12, 13};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; inst = '0; flags = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_bundle", 64'(got), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // First-instruction latency: valid appears after the second edge.
        push(tbl[0].ins, tbl[0].exp);
        @(negedge clk);
        check("latency_e", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("latency_e1", 64'(out_valid), 64'd1);
        wait_drain();

        for (int i = 0; i < 15; i++) begin
            flags = tbl[i].fl;
            push(tbl[i].ins, tbl[i].exp);
            wait_drain();
        end
        flags = 4'h0;

        // Back-to-back: three bundles on consecutive cycles.
        hs_cyc.delete();
        push(tbl[1].ins, tbl[1].exp);
        push(tbl[2].ins, tbl[2].exp);
        push(tbl[3].ins, tbl[3].exp);
        wait_drain();
        check("b2b_count", 64'(hs_cyc.size()), 64'd3);
        if (hs_cyc.size() == 3) check("b2b_span", 64'(hs_cyc[2] - hs_cyc[0]), 64'd2);

        // Stall with DEPTH+1 instructions held.
        out_ready = 1'b0;
        push(tbl[0].ins, tbl[0].exp);
        push(tbl[1].ins, tbl[1].exp);
        push(tbl[4].ins, tbl[4].exp);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_bundle", 64'(got), 64'(tbl[0].exp));
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain();

        // Random backpressure stream.
        bp_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            int k;
            k = al_set[$urandom_range(0, 7)];
            push(tbl[k].ins, tbl[k].exp);
        end
        wait_drain();
        bp_en = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Flush with FIFO full, a simultaneous offer and a simultaneous out_ready.
        out_ready = 1'b0;
        push(tbl[0].ins, tbl[0].exp);
        push(tbl[1].ins, tbl[1].exp);
        push(tbl[2].ins, tbl[2].exp);
        flush = 1'b1; in_valid = 1'b1; inst = 32'he0899999; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        push(tbl[3].ins, tbl[3].exp);
        wait_drain();

        // Reset mid-stream discards everything in flight.
        out_ready = 1'b0;
        push(tbl[1].ins, tbl[1].exp);
        push(tbl[2].ins, tbl[2].exp);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_bundle", 64'(got), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        push(tbl[12].ins, tbl[12].exp);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
